// File: rtl/ub_pkg.sv
// rtl/ub_pkg.sv - shared types, latency limits and byte-merge helper for the unified buffer
package ub_pkg;

  typedef enum logic {
    UB_IDLE  = 1'b0,
    UB_BURST = 1'b1
  } ub_state_e;

  localparam int UB_LAT_MIN = 1;
  localparam int UB_LAT_MAX = 2;

  // One byte lane of a masked write: take the new byte when its enable is set.
  function automatic logic [7:0] ub_merge_byte(input logic [7:0] old_byte,
                                               input logic [7:0] new_byte,
                                               input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ub_read_pipe.sv
// rtl/ub_read_pipe.sv - read-data delay line carrying valid/last beside the SRAM output register
module ub_read_pipe
  import ub_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int LATENCY  = UB_LAT_MIN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [WORDSIZE-1:0] in_data,
  output logic                out_valid,
  output logic                out_last,
  output logic [WORDSIZE-1:0] out_data,
  output logic                pending
);

  logic [LATENCY-1:0]                valid_q;
  logic [LATENCY-1:0]                last_q;
  logic [LATENCY-1:0][WORDSIZE-1:0]  data_q;
  logic [LATENCY:0]                  valid_chain;
  logic [LATENCY:0]                  last_chain;
  logic [LATENCY:0][WORDSIZE-1:0]    data_chain;

  assign valid_chain = {valid_q, in_valid};
  assign last_chain  = {last_q, in_valid & in_last};
  assign data_chain  = {data_q, in_data};

  // Data stages only load on a valid beat so the output holds between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_chain[LATENCY-1:0];
      last_q  <= last_chain[LATENCY-1:0];
      for (int i = 0; i < LATENCY; i++) begin
        if (valid_chain[i]) data_q[i] <= data_chain[i];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_last  = last_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign pending   = |valid_q;

endmodule

// File: rtl/sram_unified_buffer_burst.sv
// rtl/sram_unified_buffer_burst.sv - byte-write / burst-read unified buffer for the systolic array
// Optional UB_WR_FORWARD_EN: same-cycle same-address writes are merged into the read beat.
module sram_unified_buffer_burst
  import ub_pkg::*;
#(
  parameter int ADDRESSSIZE  = 15,
  parameter int WORDSIZE     = 64,
  parameter int BYTES        = WORDSIZE / 8,
  parameter int LEN_W        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDRESSSIZE-1:0] wr_addr,
  input  logic [BYTES-1:0]       wr_be,
  input  logic [WORDSIZE-1:0]    wr_data,
  input  logic                   rd_start,
  input  logic [ADDRESSSIZE-1:0] rd_base,
  input  logic [LEN_W-1:0]       rd_len,
  output logic                   rd_busy,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic [WORDSIZE-1:0]    rd_data,
  output logic                   rd_err
);

  localparam int DEPTH = 1 << ADDRESSSIZE;
  localparam int LAT   = (READ_LATENCY >= UB_LAT_MAX) ? UB_LAT_MAX : UB_LAT_MIN;

  logic [WORDSIZE-1:0]    mem [DEPTH];
  ub_state_e              state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [LEN_W-1:0]       cnt_q;
  logic                   err_q;
  logic                   accept, issue, issue_last, pipe_pending;
  logic [WORDSIZE-1:0]    rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[wr_addr][8*i +: 8] <= ub_merge_byte(mem[wr_addr][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
      end
    end
  end

  // Busy covers the issuing phase plus beats still travelling through the read pipe.
  assign rd_busy = (state_q == UB_BURST) | pipe_pending;
  assign accept  = rd_start & ~rd_busy & (rd_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UB_IDLE:  if (accept) state_d = UB_BURST;
      UB_BURST: if (cnt_q == LEN_W'(1)) state_d = UB_IDLE;
      default:  state_d = UB_IDLE;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    if (state_q == UB_BURST) begin
      issue      = 1'b1;
      issue_last = (cnt_q == LEN_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= rd_base;
        cnt_q  <= rd_len;
      end else if (issue) begin
        addr_q <= addr_q + ADDRESSSIZE'(1);
        cnt_q  <= cnt_q - LEN_W'(1);
      end
      if (rd_start && rd_busy) err_q <= 1'b1;
    end
  end

`ifdef UB_WR_FORWARD_EN
  always_comb begin
    rd_word = mem[addr_q];
    if (wr_en && (wr_addr == addr_q)) begin
      for (int i = 0; i < BYTES; i++) begin
        rd_word[8*i +: 8] = ub_merge_byte(mem[addr_q][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
      end
    end
  end
`else
  assign rd_word = mem[addr_q];
`endif

  ub_read_pipe #(
    .WORDSIZE (WORDSIZE),
    .LATENCY  (LAT)
  ) u_read_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_last   (issue_last),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_last  (rd_last),
    .out_data  (rd_data),
    .pending   (pipe_pending)
  );

  assign rd_err = err_q;

endmodule

// File: tb/tb_sram_unified_buffer_burst.sv
// tb/tb_sram_unified_buffer_burst.sv - self-checking bench for sram_unified_buffer_burst
module tb_sram_unified_buffer_burst;

  localparam int AW    = 15;
  localparam int DW    = 64;
  localparam int BY    = DW / 8;
  localparam int LW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BY-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [LW-1:0] rd_len = '0;
  logic          rd_busy, rd_valid, rd_last, rd_err;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  sram_unified_buffer_burst #(
    .ADDRESSSIZE  (AW),
    .WORDSIZE     (DW),
    .BYTES        (BY),
    .LEN_W        (LW),
    .READ_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .rd_data  (rd_data),
    .rd_err   (rd_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference: word array, a schedule for the active burst and a queue of expected beats.
  logic [DW-1:0] mem_m [DEPTH];
  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic          last;
  } beat_t;
  beat_t         outq[$];
  int            b_start = 0;
  int            b_len = 0;
  logic [AW-1:0] b_base = '0;
  int            busy_from = 0;
  int            busy_to = -1;
  logic          err_m = 1'b0;
  logic [DW-1:0] hold_m = '0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BY-1:0] be;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [BY-1:0] be);
    logic [DW-1:0] m;
    for (int i = 0; i < BY; i++) m[8*i +: 8] = {8{be[i]}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic busy_m(input int k);
    return (k >= busy_from) && (k <= busy_to);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 63))
                                       : AW'(32'h7FF0 + $urandom_range(0, 15));
  endfunction

  task automatic check_outputs();
    logic ev, el;
    ev = 1'b0;
    el = 1'b0;
    if (outq.size() > 0 && outq[0].due == cyc) begin
      ev     = 1'b1;
      el     = outq[0].last;
      hold_m = outq[0].d;
      void'(outq.pop_front());
    end
    check1("rd_valid", rd_valid, ev);
    check1("rd_last", rd_last, el);
    checkw("rd_data", rd_data, hold_m);
    check1("rd_busy", rd_busy, busy_m(cyc));
    check1("rd_err", rd_err, err_m);
  endtask

  // Applies this cycle's inputs to the reference: start decision, scheduled read, write.
  task automatic model_cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    if (rd_start) begin
      if (busy_m(cyc)) err_m = 1'b1;
      else if (rd_len != '0) begin
        b_start   = cyc + 1;
        b_len     = int'(rd_len);
        b_base    = rd_base;
        busy_from = cyc + 1;
        busy_to   = cyc + int'(rd_len) + LAT;
      end
    end
    if (cyc >= b_start && cyc < b_start + b_len) begin
      a = b_base + AW'(cyc - b_start);
      w = mem_m[a];
`ifdef UB_WR_FORWARD_EN
      if (wr_en && wr_addr == a) w = merge(w, wr_data, wr_be);
`endif
      outq.push_back('{cyc + LAT, w, (cyc == b_start + b_len - 1)});
    end
    if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [BY-1:0] be, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    step();
    idle();
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [LW-1:0] len);
    rd_start = 1'b1;
    rd_base  = base;
    rd_len   = len;
    step();
    idle();
  endtask

  initial begin
    int            acc, first, nval;
    logic [DW-1:0] lastd, exp_col;

    tbl[0] = '{15'h0010, 8'hFF, 64'h1122334455667788, 64'h1122334455667788};
    tbl[1] = '{15'h0010, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h11223344AAAAAAAA};
    tbl[2] = '{15'h0010, 8'h00, 64'h0000000000000000, 64'h11223344AAAAAAAA};
    tbl[3] = '{15'h0010, 8'h81, 64'hFFFFFFFFFFFFFFFF, 64'hFF223344AAAAAAFF};
    tbl[4] = '{15'h7FFF, 8'hFF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    tbl[5] = '{15'h7FFF, 8'h3C, 64'h0000000000000000, 64'h012300000000CDEF};

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      write(tbl[i].addr, tbl[i].be, tbl[i].data);
      start(tbl[i].addr, 8'd1);
      repeat (LAT) step();
      checkw("tbl_data", rd_data, tbl[i].exp);
      check1("tbl_valid", rd_valid, 1'b1);
      check1("tbl_last", rd_last, 1'b1);
      step();
    end

    for (int k = 0; k < 64; k++) write(AW'(k), '1, (k < 8) ? DW'(k) : {$urandom, $urandom});
    for (int k = 0; k < 16; k++) write(AW'(32'h7FF0 + k), '1, {$urandom, $urandom});

    start(15'h0000, 8'd8);
    acc   = cyc - 1;
    first = -1;
    nval  = 0;
    lastd = '1;
    for (int i = 0; i < 8 + LAT + 2; i++) begin
      if (rd_valid) begin
        if (first < 0) first = cyc;
        nval++;
        if (rd_last) lastd = rd_data;
      end
      step();
    end
    checki("stream_first", first, acc + 1 + LAT);
    checki("stream_beats", nval, 8);
    checkw("stream_lastdata", lastd, 64'd7);
    check1("stream_busy_end", rd_busy, 1'b0);

    start(15'h7FFE, 8'd4);
    repeat (4 + LAT) step();
    check1("b2b_busy_low", rd_busy, 1'b0);
    start(15'h0000, 8'd2);
    repeat (2 + LAT + 1) step();

    start(15'h0000, 8'd8);
    repeat (3) step();
    start(15'h0014, 8'd3);
    repeat (8 + LAT) step();
    check1("err_sticky", rd_err, 1'b1);
    start(15'h0000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check1("len0_busy", rd_busy, 1'b0);
      check1("len0_valid", rd_valid, 1'b0);
      step();
    end

`ifdef UB_WR_FORWARD_EN
    exp_col = '1;
`else
    exp_col = '0;
`endif
    write(15'h0005, '1, '0);
    start(15'h0003, 8'd4);
    repeat (2) step();
    write(15'h0005, '1, '1);
    repeat (LAT - 1) step();
    checkw("collide_data", rd_data, exp_col);
    check1("collide_valid", rd_valid, 1'b1);
    repeat (4) step();
    start(15'h0005, 8'd1);
    repeat (LAT) step();
    checkw("collide_reread", rd_data, '1);
    repeat (2) step();

    start(15'h0000, 8'd8);
    repeat (LAT + 2) step();
    check1("mid_valid", rd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    outq.delete();
    busy_to = -1;
    b_len   = 0;
    err_m   = 1'b0;
    hold_m  = '0;
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    rst_n = 1'b1;
    start(15'h7FF8, 8'd5);
    repeat (5 + LAT + 1) step();

    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = rand_addr();
      wr_be    = BY'($urandom);
      wr_data  = {$urandom, $urandom};
      rd_start = ($urandom_range(0, 5) == 0);
      rd_base  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 47))
                                             : AW'(32'h7FF0 + $urandom_range(0, 15));
      rd_len   = LW'($urandom_range(0, 16));
      step();
    end
    idle();
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
